mem_datos_param: RTL and testbench

Parametrised data memory for the datapath. Supports byte, halfword and word loads and stores, with optional sign extension, a configurable number of wait states, and a request/ready handshake. It sits between the ALU/address path and the write-back mux, in the slot of the earlier fixed 128×32 data memory. Depth and access latency are set by parameters; the subword lane logic and alignment checking are new behaviour.

---
 rtl/mem_datos_param.sv | 159 +++++++++++++++
 tb/tb_mem_datos_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_datos_param.sv
// Parametrised byte/half/word data memory with wait states and req/listo handshake.
// Define MEM_CHK_ALIN_EN to flag misaligned half/word accesses as errors.
module mem_datos_param #(
  parameter int PROF   = 128,
  parameter int ESPERA = 0,
  parameter int DIR_W  = $clog2(PROF) + 2
) (
  input  logic             reloj,
  input  logic             reset_n,
  input  logic             req,
  input  logic             MEM_RD,
  input  logic             MEM_WR,
  input  logic [1:0]       tam,
  input  logic             sig,
  input  logic [DIR_W-1:0] DIR_MEM,
  input  logic [31:0]      DI_MEM,
  output logic [31:0]      DO_MEM,
  output logic             listo,
  output logic             err,
  output logic             ocupado
);

  localparam logic [3:0] CNT_INI =
    (ESPERA > 0) ? 4'(ESPERA - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    ESPERA_ST,
    ACCESO,
    RESP
  } state_t;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [1:0]       tam;
    logic             sig;
    logic [DIR_W-1:0] dir;
    logic [31:0]      dat;
  } cmd_t;

  state_t            st, st_nx;
  cmd_t              cmd;
  logic [3:0]        cnt;
  logic [31:0]       mem [PROF];

  logic              acepta;
  logic [1:0]        lane;
  logic [DIR_W-3:0]  idx;
  logic              mal_cmd;
  logic              desal;
  logic              fallo;
  logic              escribe;
  logic              lee;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       rw;
  logic [7:0]        rb;
  logic [15:0]       rh;
  logic [31:0]       ld;

  assign acepta  = (st == IDLE) & req & (MEM_RD | MEM_WR);
  assign ocupado = (st != IDLE);

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:      if (acepta)
                   st_nx = (ESPERA > 0) ? ESPERA_ST : ACCESO;
      ESPERA_ST: if (cnt == 4'd0) st_nx = ACCESO;
      ACCESO:    st_nx = RESP;
      RESP:      st_nx = IDLE;
      default:   st_nx = IDLE;
    endcase
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      st  <= IDLE;
      cmd <= '0;
      cnt <= 4'd0;
    end else begin
      st <= st_nx;
      if (acepta) begin
        cmd <= '{MEM_RD, MEM_WR, tam, sig, DIR_MEM, DI_MEM};
        cnt <= CNT_INI;
      end else if (st == ESPERA_ST && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign lane    = cmd.dir[1:0];
  assign idx     = cmd.dir[DIR_W-1:2];
  assign mal_cmd = (cmd.rd & cmd.wr) | (cmd.tam == 2'b11);

`ifdef MEM_CHK_ALIN_EN
  assign desal = ((cmd.tam == 2'b01) & lane[0]) |
                 ((cmd.tam == 2'b10) & (lane != 2'b00));
`else
  assign desal = 1'b0;
`endif

  assign fallo   = mal_cmd | desal;
  assign escribe = (st == ACCESO) & cmd.wr & ~fallo;
  assign lee     = (st == ACCESO) & cmd.rd & ~fallo;

  // store data is replicated across lanes; be picks which land
  always_comb begin
    be = 4'b0000;
    wd = cmd.dat;
    unique case (1'b1)
      cmd.tam == 2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{cmd.dat[7:0]}};
      end
      cmd.tam == 2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{cmd.dat[15:0]}};
      end
      cmd.tam == 2'b10: be = 4'b1111;
      default:          be = 4'b0000;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (escribe) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign rw = mem[idx];
  assign rb = rw[{lane, 3'b000} +: 8];
  assign rh = lane[1] ? rw[31:16] : rw[15:0];

  always_comb begin
    ld = rw;
    unique case (1'b1)
      cmd.tam == 2'b00: ld = {{24{cmd.sig & rb[7]}}, rb};
      cmd.tam == 2'b01: ld = {{16{cmd.sig & rh[15]}}, rh};
      default:          ld = rw;
    endcase
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      DO_MEM <= 32'd0;
      listo  <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (lee) DO_MEM <= ld;
      listo <= (st == ACCESO);
      err   <= (st == ACCESO) & fallo;
    end
  end

endmodule

// File: tb/tb_mem_datos_param.sv
// Directed bench for mem_datos_param: three instances with 0, 3 and 4 wait states.
// Honours MEM_CHK_ALIN_EN when computing alignment expectations.
module tb_mem_datos_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  reqv;
  logic        rd, wr, sg;
  logic [1:0]  tm;
  logic [8:0]  dir;
  logic [31:0] di;

  logic [31:0] do0, do3, do4;
  logic        l0, l3, l4, e0, e3, e4, o0, o3, o4;

  int total = 0;
  int bad   = 0;

  logic [31:0] q;
  logic        e;
  int          lat;
  int          busy;
  logic        seen;

  always #5 clk = ~clk;

  mem_datos_param #(.PROF(128), .ESPERA(0)) u0 (
    .reloj(clk), .reset_n(rst_n), .req(reqv[0]),
    .MEM_RD(rd), .MEM_WR(wr), .tam(tm), .sig(sg),
    .DIR_MEM(dir), .DI_MEM(di), .DO_MEM(do0),
    .listo(l0), .err(e0), .ocupado(o0));

  mem_datos_param #(.PROF(128), .ESPERA(3)) u3 (
    .reloj(clk), .reset_n(rst_n), .req(reqv[1]),
    .MEM_RD(rd), .MEM_WR(wr), .tam(tm), .sig(sg),
    .DIR_MEM(dir), .DI_MEM(di), .DO_MEM(do3),
    .listo(l3), .err(e3), .ocupado(o3));

  mem_datos_param #(.PROF(128), .ESPERA(4)) u4 (
    .reloj(clk), .reset_n(rst_n), .req(reqv[2]),
    .MEM_RD(rd), .MEM_WR(wr), .tam(tm), .sig(sg),
    .DIR_MEM(dir), .DI_MEM(di), .DO_MEM(do4),
    .listo(l4), .err(e4), .ocupado(o4));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic lst(input int w);
    case (w)
      0:       return l0;
      1:       return l3;
      default: return l4;
    endcase
  endfunction

  function automatic logic ocu(input int w);
    case (w)
      0:       return o0;
      1:       return o3;
      default: return o4;
    endcase
  endfunction

  function automatic logic [31:0] dox(input int w);
    case (w)
      0:       return do0;
      1:       return do3;
      default: return do4;
    endcase
  endfunction

  function automatic logic erx(input int w);
    case (w)
      0:       return e0;
      1:       return e3;
      default: return e4;
    endcase
  endfunction

  // One transaction; poke>0 fires a store req on the busy DUT at that sample.
  task automatic run(input int w, input logic r, input logic wv,
                     input logic [1:0] t, input logic s,
                     input logic [8:0] a, input logic [31:0] d,
                     input int poke);
    @(negedge clk);
    rd = r; wr = wv; tm = t; sg = s; dir = a; di = d;
    reqv = 3'b000;
    reqv[w] = 1'b1;
    @(negedge clk);
    reqv = 3'b000;
    lat = 1; busy = 0; seen = 1'b0;
    while (lat < 40) begin
      if (ocu(w)) busy++;
      if (lst(w)) begin
        seen = 1'b1;
        q = dox(w);
        e = erx(w);
        break;
      end
      if (lat == poke) begin
        rd = 1'b0; wr = 1'b1; tm = 2'b10; di = 32'h1234_5678;
        reqv[w] = 1'b1;
      end else begin
        reqv = 3'b000;
      end
      @(negedge clk);
      lat++;
    end
    reqv = 3'b000;
    if (!seen) begin
      total++; bad++;
      $error("FAIL timeout observed=no_listo expected=listo");
    end
    @(negedge clk);
    if (ocu(w)) busy++;
  endtask

  initial begin
    rst_n = 1'b0;
    reqv = 3'b000;
    rd = 0; wr = 0; tm = 0; sg = 0; dir = 0; di = 0;
    repeat (3) @(negedge clk);
    chk("rst_do",    do0, 32'h0);
    chk("rst_listo", {31'b0, l0}, 32'h0);
    chk("rst_err",   {31'b0, e0}, 32'h0);
    chk("rst_ocup",  {31'b0, o0}, 32'h0);
    rst_n = 1'b1;

    // ignored request: neither read nor write
    @(negedge clk);
    reqv = 3'b001;
    @(negedge clk);
    reqv = 3'b000;
    chk("noop_ocup", {31'b0, o0}, 32'h0);

    run(0, 0, 1, 2'b10, 0, 9'h10, 32'hDEAD_BEEF, 0);
    chk("sw_lat", lat, 2);
    chk("sw_err", {31'b0, e}, 32'h0);
    chk("do_before", do0, 32'h0);
    run(0, 1, 0, 2'b10, 0, 9'h10, 32'h0, 0);
    chk("lw_lat", lat, 2);
    chk("lw_data", q, 32'hDEAD_BEEF);
    chk("lw_err", {31'b0, e}, 32'h0);

    run(0, 0, 1, 2'b10, 0, 9'h20, 32'h0, 0);
    run(0, 0, 1, 2'b00, 0, 9'h23, 32'hAAAA_AA80, 0);
    run(0, 1, 0, 2'b10, 0, 9'h20, 32'h0, 0);
    chk("lane_word", q, 32'h8000_0000);
    run(0, 1, 0, 2'b00, 1, 9'h23, 32'h0, 0);
    chk("lb_sext", q, 32'hFFFF_FF80);
    run(0, 1, 0, 2'b00, 0, 9'h23, 32'h0, 0);
    chk("lb_zext", q, 32'h0000_0080);

    run(0, 0, 1, 2'b01, 0, 9'h22, 32'h1234_C3A5, 0);
    run(0, 1, 0, 2'b10, 0, 9'h20, 32'h0, 0);
    chk("sh_word", q, 32'hC3A5_0000);
    run(0, 1, 0, 2'b01, 1, 9'h22, 32'h0, 0);
    chk("lh_sext", q, 32'hFFFF_C3A5);
    run(0, 1, 0, 2'b01, 0, 9'h22, 32'h0, 0);
    chk("lh_zext", q, 32'h0000_C3A5);
    run(0, 1, 0, 2'b00, 1, 9'h22, 32'h0, 0);
    chk("lb2_sext", q, 32'hFFFF_FFA5);

    run(0, 1, 1, 2'b10, 0, 9'h10, 32'h0, 0);
    chk("rdwr_err", {31'b0, e}, 32'h1);
    chk("rdwr_hold", q, 32'hFFFF_FFA5);
    run(0, 1, 0, 2'b11, 0, 9'h10, 32'h0, 0);
    chk("tam3_err", {31'b0, e}, 32'h1);
    chk("tam3_hold", q, 32'hFFFF_FFA5);

    run(0, 0, 1, 2'b10, 0, 9'h21, 32'h1122_3344, 0);
`ifdef MEM_CHK_ALIN_EN
    chk("alin_err", {31'b0, e}, 32'h1);
    run(0, 1, 0, 2'b10, 0, 9'h20, 32'h0, 0);
    chk("alin_word", q, 32'hC3A5_0000);
`else
    chk("alin_err", {31'b0, e}, 32'h0);
    run(0, 1, 0, 2'b10, 0, 9'h20, 32'h0, 0);
    chk("alin_word", q, 32'h1122_3344);
`endif

    run(1, 0, 1, 2'b10, 0, 9'h40, 32'h55AA_55AA, 0);
    chk("ws_st_lat", lat, 5);
    run(1, 1, 0, 2'b10, 0, 9'h40, 32'h0, 2);
    chk("ws_ld_lat", lat, 5);
    chk("ws_busy", busy, 5);
    chk("ws_data", q, 32'h55AA_55AA);
    chk("ws_err", {31'b0, e}, 32'h0);
    run(1, 1, 0, 2'b10, 0, 9'h40, 32'h0, 0);
    chk("ws_poke", q, 32'h55AA_55AA);

    run(2, 0, 1, 2'b10, 0, 9'h08, 32'h0F0F_0F0F, 0);
    chk("w4_lat", lat, 6);
    @(negedge clk);
    rd = 0; wr = 1; tm = 2'b10; dir = 9'h08; di = 32'hFFFF_FFFF;
    reqv = 3'b100;
    @(negedge clk);
    reqv = 3'b000;
    @(negedge clk);
    chk("mid_busy", {31'b0, o4}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_idle", {31'b0, o4}, 32'h0);
    chk("mid_do0", do0, 32'h0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (l4) seen = 1'b1;
    end
    chk("mid_nolisto", {31'b0, seen}, 32'h0);
    rst_n = 1'b1;
    run(2, 1, 0, 2'b10, 0, 9'h08, 32'h0, 0);
    chk("mid_word", q, 32'h0F0F_0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
